// File: rtl/data_bank_arbiter_pkg.sv
// Shared OBI field widths, master-index type and small index helpers for the
// per-bank data-memory arbiter.
package data_bank_arbiter_pkg;

    localparam int OBI_NUM_MASTER = 4;
    localparam int OBI_ADDR_WIDTH = 32;
    localparam int OBI_DATA_WIDTH = 32;
    localparam int OBI_BE_WIDTH   = OBI_DATA_WIDTH / 8;
    localparam int OBI_MAX_OUTST  = 2;

    typedef logic [$clog2(OBI_NUM_MASTER)-1:0] obi_mst_idx_t;
    typedef logic [OBI_ADDR_WIDTH-1:0]         obi_addr_t;
    typedef logic [OBI_DATA_WIDTH-1:0]         obi_data_t;
    typedef logic [OBI_BE_WIDTH-1:0]           obi_be_t;

    // Slot visited at a given offset from the round-robin base.
    function automatic int rr_slot(input int base, input int offset, input int modulus);
        return (base + offset) % modulus;
    endfunction

    // Circular pointer advance for the response-ID queue.
    function automatic int ptr_next(input int ptr, input int depth);
        return (ptr >= depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/data_bank_arbiter_id_fifo.sv
// In-flight master-ID queue: records who was granted so bank responses,
// which come back in request order, can be routed to the right master.
module arb_id_fifo
    import data_bank_arbiter_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int WIDTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       empty_o,
    output logic                       full_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Push is legal when space exists or a pop frees a slot in the same cycle.
    always_comb begin
        empty_o   = (count_r == CNT_W'(0));
        full_o    = (count_r == CNT_W'(DEPTH));
        pop_ok_s  = pop_i && !empty_o;
        push_ok_s = push_i && (!full_o || pop_ok_s);
        head_o    = mem_r[rd_ptr_r];
        count_o   = count_r;
    end

    // Entry storage; contents are don't-care until the count covers them.
    always_ff @(posedge clk_i) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data_i;
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_r <= PTR_W'(0);
            rd_ptr_r <= PTR_W'(0);
            count_r  <= CNT_W'(0);
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= PTR_W'(ptr_next(int'(wr_ptr_r), DEPTH));
            end
            if (pop_ok_s) begin
                rd_ptr_r <= PTR_W'(ptr_next(int'(rd_ptr_r), DEPTH));
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/data_bank_arbiter.sv
// Round-robin arbiter letting NUM_MASTER OBI requesters share one data-memory
// bank port, with in-order response routing and a sticky protocol-error flag.
module data_bank_arbiter
    import data_bank_arbiter_pkg::*;
#(
    parameter int NUM_MASTER      = OBI_NUM_MASTER,
    parameter int ADDR_WIDTH      = OBI_ADDR_WIDTH,
    parameter int DATA_WIDTH      = OBI_DATA_WIDTH,
    parameter int MAX_OUTSTANDING = OBI_MAX_OUTST
) (
    input  logic                                     clk_i,
    input  logic                                     rst_i,
    input  logic [NUM_MASTER-1:0]                    m_req_i,
    output logic [NUM_MASTER-1:0]                    m_gnt_o,
    input  logic [NUM_MASTER-1:0][ADDR_WIDTH-1:0]    m_addr_i,
    input  logic [NUM_MASTER-1:0]                    m_we_i,
    input  logic [NUM_MASTER-1:0][DATA_WIDTH/8-1:0]  m_be_i,
    input  logic [NUM_MASTER-1:0][DATA_WIDTH-1:0]    m_wdata_i,
    output logic [NUM_MASTER-1:0]                    m_rvalid_o,
    output logic [DATA_WIDTH-1:0]                    m_rdata_o,
    output logic                                     s_req_o,
    output logic [ADDR_WIDTH-1:0]                    s_addr_o,
    output logic                                     s_we_o,
    output logic [DATA_WIDTH/8-1:0]                  s_be_o,
    output logic [DATA_WIDTH-1:0]                    s_wdata_o,
    input  logic                                     s_gnt_i,
    input  logic                                     s_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                    s_rdata_i,
    output logic                                     err_o
);

    localparam int IDX_W = (NUM_MASTER > 1) ? $clog2(NUM_MASTER) : 1;
    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic [IDX_W-1:0] rr_ptr_r;
    logic [IDX_W-1:0] win_idx_s;
    logic             win_found_s;
    logic [IDX_W-1:0] head_idx_s;
    logic [CNT_W-1:0] fifo_count_s;
    logic             fifo_empty_s;
    logic             fifo_full_s;
    logic             accept_ok_s;
    logic             hs_s;
    logic             pop_s;
    logic             err_r;

    // Round-robin pick: first requester at or after rr_ptr, wrapping.
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = IDX_W'(0);
        for (int i = 0; i < NUM_MASTER; i++) begin
            if (!win_found_s && m_req_i[rr_slot(int'(rr_ptr_r), i, NUM_MASTER)]) begin
                win_found_s = 1'b1;
                win_idx_s   = IDX_W'(rr_slot(int'(rr_ptr_r), i, NUM_MASTER));
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // A response arriving this cycle frees a slot, so a full queue can still accept.
    always_comb begin
        accept_ok_s = (fifo_count_s < CNT_W'(MAX_OUTSTANDING)) || s_rvalid_i;
        s_req_o     = win_found_s && accept_ok_s;
        hs_s        = s_req_o && s_gnt_i;
        pop_s       = s_rvalid_i && !fifo_empty_s;
        s_addr_o    = m_addr_i[win_idx_s];
        s_we_o      = m_we_i[win_idx_s];
        s_be_o      = m_be_i[win_idx_s];
        s_wdata_o   = m_wdata_i[win_idx_s];
        m_rdata_o   = s_rdata_i;
        err_o       = err_r;
    end

    // One-hot grant and response-valid steering.
    always_comb begin
        m_gnt_o    = '0;
        m_rvalid_o = '0;
        if (hs_s) begin
            m_gnt_o[win_idx_s] = 1'b1;
        end else begin
            m_gnt_o = '0;
        end
        if (pop_s) begin
            m_rvalid_o[head_idx_s] = 1'b1;
        end else begin
            m_rvalid_o = '0;
        end
    end

    // Priority moves past the winner only on a completed handshake.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rr_ptr_r <= IDX_W'(0);
        end else if (hs_s) begin
            rr_ptr_r <= IDX_W'(rr_slot(int'(win_idx_s), 1, NUM_MASTER));
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end

    // A response with nothing in flight is a protocol violation; latch it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            err_r <= 1'b0;
        end else if (s_rvalid_i && fifo_empty_s) begin
            err_r <= 1'b1;
        end else begin
            err_r <= err_r;
        end
    end

    arb_id_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (IDX_W)
    ) u_id_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (hs_s),
        .push_data_i (win_idx_s),
        .pop_i       (pop_s),
        .head_o      (head_idx_s),
        .count_o     (fifo_count_s),
        .empty_o     (fifo_empty_s),
        .full_o      (fifo_full_s)
    );

endmodule

// File: tb/tb_data_bank_arbiter.sv
// Directed and randomized checks of data_bank_arbiter against a queue-based
// reference model of round-robin arbitration and in-order response routing.
module tb_data_bank_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = DW / 8;
    localparam int MO = 2;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [N-1:0]           m_req;
    logic [N-1:0]           m_gnt;
    logic [N-1:0][AW-1:0]   m_addr;
    logic [N-1:0]           m_we;
    logic [N-1:0][BW-1:0]   m_be;
    logic [N-1:0][DW-1:0]   m_wdata;
    logic [N-1:0]           m_rvalid;
    logic [DW-1:0]          m_rdata;
    logic                   s_req;
    logic [AW-1:0]          s_addr;
    logic                   s_we;
    logic [BW-1:0]          s_be;
    logic [DW-1:0]          s_wdata;
    logic                   s_gnt;
    logic                   s_rvalid;
    logic [DW-1:0]          s_rdata;
    logic                   err;

    int tests = 0;
    int fails = 0;

    int rr_m;
    int q_m[$];
    bit err_m;

    logic [N-1:0]  last_gnt;
    logic [N-1:0]  last_rvalid;
    logic          last_sreq;
    logic [AW-1:0] last_saddr;

    always #5 clk = ~clk;

    data_bank_arbiter #(
        .NUM_MASTER      (N),
        .ADDR_WIDTH      (AW),
        .DATA_WIDTH      (DW),
        .MAX_OUTSTANDING (MO)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .m_req_i    (m_req),
        .m_gnt_o    (m_gnt),
        .m_addr_i   (m_addr),
        .m_we_i     (m_we),
        .m_be_i     (m_be),
        .m_wdata_i  (m_wdata),
        .m_rvalid_o (m_rvalid),
        .m_rdata_o  (m_rdata),
        .s_req_o    (s_req),
        .s_addr_o   (s_addr),
        .s_we_o     (s_we),
        .s_be_o     (s_be),
        .s_wdata_o  (s_wdata),
        .s_gnt_i    (s_gnt),
        .s_rvalid_i (s_rvalid),
        .s_rdata_i  (s_rdata),
        .err_o      (err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rand_payload();
        for (int k = 0; k < N; k++) begin
            m_addr[k]  = $urandom;
            m_we[k]    = 1'($urandom_range(0, 1));
            m_be[k]    = 4'($urandom_range(0, 15));
            m_wdata[k] = $urandom;
        end
    endtask

    // One clock cycle: apply inputs, check outputs against the model, advance the model.
    task automatic drive(input logic [N-1:0] req, input logic gnt, input logic rv, input logic rs);
        int win;
        bit sreq_e, hs_e, pop_e;
        logic [N-1:0] gnt_e, rv_e;
        @(negedge clk);
        rst      = rs;
        m_req    = req;
        s_gnt    = gnt;
        s_rvalid = rv;
        s_rdata  = $urandom;
        #1;
        win = -1;
        for (int k = 0; k < N; k++) begin
            if (win < 0 && req[(rr_m + k) % N]) win = (rr_m + k) % N;
        end
        sreq_e = (win >= 0) && ((q_m.size() < MO) || rv);
        hs_e   = sreq_e && gnt;
        pop_e  = rv && (q_m.size() > 0);
        gnt_e  = '0;
        rv_e   = '0;
        if (hs_e) gnt_e[win] = 1'b1;
        if (pop_e) rv_e[q_m[0]] = 1'b1;
        last_gnt    = m_gnt;
        last_rvalid = m_rvalid;
        last_sreq   = s_req;
        last_saddr  = s_addr;
        chk("s_req", 64'(s_req), 64'(sreq_e));
        chk("m_gnt", 64'(m_gnt), 64'(gnt_e));
        chk("m_rvalid", 64'(m_rvalid), 64'(rv_e));
        chk("err", 64'(err), 64'(err_m));
        if (pop_e) chk("m_rdata", 64'(m_rdata), 64'(s_rdata));
        if (win >= 0) begin
            chk("s_addr", 64'(s_addr), 64'(m_addr[win]));
            chk("s_we", 64'(s_we), 64'(m_we[win]));
            chk("s_be", 64'(s_be), 64'(m_be[win]));
            chk("s_wdata", 64'(s_wdata), 64'(m_wdata[win]));
        end
        @(posedge clk);
        #1;
        if (rs) begin
            rr_m = 0;
            q_m.delete();
            err_m = 1'b0;
        end else begin
            if (pop_e) void'(q_m.pop_front());
            if (rv && !pop_e) err_m = 1'b1;
            if (hs_e) begin
                q_m.push_back(win);
                rr_m = (win + 1) % N;
            end
        end
        chk("rr_ptr", 64'(dut.rr_ptr_r), 64'(rr_m));
        chk("fifo_count", 64'(dut.fifo_count_s), 64'(q_m.size()));
    endtask

    task automatic do_reset();
        drive('0, 1'b0, 1'b0, 1'b1);
        drive('0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        rst      = 1'b1;
        m_req    = '0;
        s_gnt    = 1'b0;
        s_rvalid = 1'b0;
        s_rdata  = '0;
        rand_payload();
        repeat (3) @(posedge clk);
        #1;
        rr_m  = 0;
        err_m = 1'b0;
        q_m.delete();

        // Reset state
        drive(4'b0000, 1'b0, 1'b0, 1'b0);
        chk("rst_rvalid", 64'(last_rvalid), 64'(0));
        chk("rst_gnt", 64'(last_gnt), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_cnt", 64'(dut.fifo_count_s), 64'(0));

        // Masters 0 and 2 alternate
        do_reset();
        drive(4'b0101, 1'b1, 1'b0, 1'b0);
        chk("alt_g0", 64'(last_gnt), 64'(4'b0001));
        chk("alt_rr0", 64'(dut.rr_ptr_r), 64'(1));
        drive(4'b0101, 1'b1, 1'b1, 1'b0);
        chk("alt_g1", 64'(last_gnt), 64'(4'b0100));
        chk("alt_rr1", 64'(dut.rr_ptr_r), 64'(3));
        drive(4'b0101, 1'b1, 1'b1, 1'b0);
        chk("alt_g2", 64'(last_gnt), 64'(4'b0001));
        chk("alt_rr2", 64'(dut.rr_ptr_r), 64'(1));
        drive(4'b0101, 1'b1, 1'b1, 1'b0);
        chk("alt_g3", 64'(last_gnt), 64'(4'b0100));
        chk("alt_rr3", 64'(dut.rr_ptr_r), 64'(3));

        // All four request, bank answers one cycle later
        do_reset();
        drive(4'b1111, 1'b1, 1'b0, 1'b0);
        chk("all_g0", 64'(last_gnt), 64'(4'b0001));
        drive(4'b1111, 1'b1, 1'b1, 1'b0);
        chk("all_g1", 64'(last_gnt), 64'(4'b0010));
        chk("all_r0", 64'(last_rvalid), 64'(4'b0001));
        drive(4'b1111, 1'b1, 1'b1, 1'b0);
        chk("all_g2", 64'(last_gnt), 64'(4'b0100));
        chk("all_r1", 64'(last_rvalid), 64'(4'b0010));
        drive(4'b1111, 1'b1, 1'b1, 1'b0);
        chk("all_g3", 64'(last_gnt), 64'(4'b1000));
        chk("all_r2", 64'(last_rvalid), 64'(4'b0100));
        drive(4'b0000, 1'b0, 1'b1, 1'b0);
        chk("all_r3", 64'(last_rvalid), 64'(4'b1000));

        // Outstanding limit: stall at two, reopen on the first response
        do_reset();
        drive(4'b0001, 1'b1, 1'b0, 1'b0);
        drive(4'b0001, 1'b1, 1'b0, 1'b0);
        chk("lim_cnt2", 64'(dut.fifo_count_s), 64'(2));
        drive(4'b0001, 1'b1, 1'b0, 1'b0);
        chk("lim_sreq0", 64'(last_sreq), 64'(0));
        chk("lim_gnt0", 64'(last_gnt), 64'(0));
        drive(4'b0001, 1'b1, 1'b1, 1'b0);
        chk("lim_sreq1", 64'(last_sreq), 64'(1));
        chk("lim_gnt1", 64'(last_gnt), 64'(4'b0001));
        chk("lim_cnt_keep", 64'(dut.fifo_count_s), 64'(2));

        // Stalled master 1 keeps priority while master 3 joins
        do_reset();
        m_addr[1] = 32'hA11C_0001;
        m_addr[3] = 32'hA33C_0003;
        drive(4'b0010, 1'b0, 1'b0, 1'b0);
        drive(4'b0010, 1'b0, 1'b0, 1'b0);
        for (int c = 0; c < 3; c++) begin
            drive(4'b1010, 1'b0, 1'b0, 1'b0);
            chk("stall_addr", 64'(last_saddr), 64'(32'hA11C_0001));
            chk("stall_gnt", 64'(last_gnt), 64'(0));
        end
        drive(4'b1010, 1'b1, 1'b0, 1'b0);
        chk("stall_win", 64'(last_gnt), 64'(4'b0010));
        drive(4'b1010, 1'b1, 1'b0, 1'b0);
        chk("stall_next", 64'(last_gnt), 64'(4'b1000));

        // Response with nothing in flight
        do_reset();
        drive(4'b0000, 1'b0, 1'b1, 1'b0);
        chk("orphan_rv", 64'(last_rvalid), 64'(0));
        chk("orphan_err", 64'(err), 64'(1));
        drive(4'b0000, 1'b0, 1'b0, 1'b0);
        chk("orphan_sticky", 64'(err), 64'(1));
        drive(4'b0000, 1'b0, 1'b0, 1'b1);
        chk("orphan_clr", 64'(err), 64'(0));

        // Reset with two IDs in flight
        do_reset();
        drive(4'b0011, 1'b1, 1'b0, 1'b0);
        drive(4'b0011, 1'b1, 1'b0, 1'b0);
        chk("inflt_cnt", 64'(dut.fifo_count_s), 64'(2));
        drive(4'b0000, 1'b0, 1'b0, 1'b1);
        chk("inflt_cnt0", 64'(dut.fifo_count_s), 64'(0));
        chk("inflt_rr0", 64'(dut.rr_ptr_r), 64'(0));
        drive(4'b0000, 1'b0, 1'b1, 1'b0);
        chk("late_rv", 64'(last_rvalid), 64'(0));
        chk("late_err", 64'(err), 64'(1));

        // Randomized traffic against the model
        do_reset();
        for (int c = 0; c < 600; c++) begin
            logic [N-1:0] r;
            logic g, v, s;
            if ($urandom_range(0, 3) == 0) rand_payload();
            r = N'($urandom_range(0, 15));
            g = ($urandom_range(0, 3) != 0);
            v = ($urandom_range(0, 2) == 0) && (q_m.size() > 0);
            if ($urandom_range(0, 199) == 0) v = 1'b1;
            s = ($urandom_range(0, 149) == 0);
            drive(r, g, v, s);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/data_bank_arbiter.md
DATA_BANK_ARBITER -- requirements
Module: data_bank_arbiter

Interface
REQ-001 SHALL have parameter NUM_MASTER, default 4, number of OBI requesters sharing one data-memory bank (2..8).
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, OBI address width.
REQ-003 SHALL have parameter DATA_WIDTH, default 32, OBI data width; byte enables are DATA_WIDTH/8.
REQ-004 SHALL have parameter MAX_OUTSTANDING, default 2, depth of the in-flight response-ID FIFO (1..4).
REQ-005 clk_i  input  1  single clock; all state updates on its rising edge.
REQ-006 rst_i  input  1  reset, synchronous, active-high.
REQ-007 m_req_i  input  NUM_MASTER  per-master OBI request.
REQ-008 m_gnt_o  output  NUM_MASTER  per-master OBI grant, at most one bit set.
REQ-009 m_addr_i / m_we_i / m_be_i / m_wdata_i  input  NUM_MASTER x (ADDR_WIDTH / 1 / DATA_WIDTH/8 / DATA_WIDTH)  per-master request payload.
REQ-010 m_rvalid_o  output  NUM_MASTER  per-master response valid, at most one bit set.
REQ-011 m_rdata_o  output  DATA_WIDTH  response data, shared by all masters, qualified by m_rvalid_o.
REQ-012 s_req_o / s_addr_o / s_we_o / s_be_o / s_wdata_o  output  1 / ADDR_WIDTH / 1 / DATA_WIDTH/8 / DATA_WIDTH  request toward the bank.
REQ-013 s_gnt_i  input  1  bank grant.
REQ-014 s_rvalid_i / s_rdata_i  input  1 / DATA_WIDTH  bank response; the bank responds in request order.
REQ-015 err_o  output  1  sticky protocol-error flag.

Function
REQ-016 Arbitration SHALL be round-robin: the winner is the first requesting master at index rr_ptr, rr_ptr+1, ... modulo NUM_MASTER.
REQ-017 The winner and the s_* payload mux SHALL be combinational from m_req_i and rr_ptr, giving zero-cycle request latency.
REQ-018 s_req_o SHALL be |m_req_i AND accept_ok, where accept_ok = (fifo_count < MAX_OUTSTANDING) OR s_rvalid_i.
REQ-019 m_gnt_o[winner] SHALL equal s_req_o AND s_gnt_i; all other grant bits SHALL be 0.
REQ-020 A handshake (s_req_o AND s_gnt_i) SHALL set rr_ptr to (winner+1) mod NUM_MASTER and push winner into the ID FIFO.
REQ-021 Without a handshake, rr_ptr SHALL hold, so a stalled winner keeps priority.
REQ-022 On s_rvalid_i with a non-empty FIFO, the arbiter SHALL set m_rvalid_o[head] = 1 in the same cycle, drive m_rdata_o = s_rdata_i, and pop the FIFO.
REQ-023 A simultaneous push and pop SHALL leave fifo_count unchanged and preserve order, including when the FIFO is full.
REQ-024 On s_rvalid_i with an empty FIFO, the response SHALL be dropped (m_rvalid_o = 0) and err_o SHALL be set until reset.
REQ-025 The FIFO pointers SHALL wrap modulo MAX_OUTSTANDING, and fifo_count SHALL range 0..MAX_OUTSTANDING.
REQ-026 A master that deasserts m_req_i before its grant SHALL lose nothing; the next requester in order wins.

Reset
REQ-027 While rst_i is high at a clock edge, the block SHALL set rr_ptr = 0, empty the FIFO (count, read and write pointers = 0) and clear err_o.
REQ-028 During and after reset, m_gnt_o, m_rvalid_o and s_req_o SHALL follow REQ-018 to REQ-022 from the cleared state, so m_rvalid_o = 0 immediately after reset.
REQ-029 Reset mid-transaction SHALL discard in-flight IDs; a late s_rvalid_i after reset SHALL set err_o.

Structure
REQ-030 The OBI request/response field widths and a master-index typedef, sized $clog2(NUM_MASTER), SHALL live in the shared obi package alongside the existing memory-map package.
REQ-031 The ID FIFO SHALL be a sub-module arb_id_fifo (parameters DEPTH and WIDTH; push, pop, head, count); the round-robin pick SHALL stay inline.
REQ-032 The block SHALL sit between the interleaved bus interconnect's per-bank slave port and data_mem bank ports, one instance per bank.

Verification
REQ-033 Masters 0 and 2 request continuously with s_gnt_i = 1 -> grants alternate 0,2,0,2; rr_ptr after each handshake is 1,3,1,3.
REQ-034 All 4 masters request with s_gnt_i = 1 and the bank returns rvalid 1 cycle later -> grant order 0,1,2,3, and m_rvalid_o is one-hot 0001, 0010, 0100, 1000 one cycle after each grant.
REQ-035 MAX_OUTSTANDING = 2, bank grants but withholds rvalid -> 2 handshakes then s_req_o = 0; on the first s_rvalid_i, s_req_o rises the same cycle and count stays 2.
REQ-036 Master 1 requests with s_gnt_i = 0 for 5 cycles while master 3 joins -> master 1 is granted first once s_gnt_i = 1, with payload stable on s_*.
REQ-037 s_rvalid_i pulses with an empty FIFO -> all m_rvalid_o = 0 and err_o = 1 until rst_i.
REQ-038 rst_i asserted with 2 IDs in flight -> count = 0 and rr_ptr = 0 next cycle; a subsequent s_rvalid_i sets err_o.
